// File: rtl/machine_trap_csr_pkg.sv
// Shared constants for the machine-mode trap CSR bank: CSR addresses,
// access opcodes, mtvec mode encodings and the mtvec mode legaliser.
package machine_trap_csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [1:0] MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MODE_VECTORED = 2'b01;

  // Only direct and (when enabled) vectored modes survive; anything else
  // collapses to direct.
  function automatic logic [1:0] legal_mode(input logic [1:0] mode, input logic vectored_en);
    if (vectored_en && (mode == MODE_VECTORED)) begin
      return MODE_VECTORED;
    end
    return MODE_DIRECT;
  endfunction

endpackage

// File: rtl/machine_trap_csr_rmw_unit.sv
// Zicsr read/modify/write combiner, shared by every register in the bank.
module csr_rmw_unit
  import machine_trap_csr_pkg::*;
(
  input  logic [31:0] old_value,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] new_value
);

  // Produce the post-access value; no-op leaves the register unchanged.
  always_comb begin
    new_value = old_value;
    case (op)
      OP_RW:   new_value = wdata;
      OP_RS:   new_value = old_value | wdata;
      OP_RC:   new_value = old_value & ~wdata;
      default: new_value = old_value;
    endcase
  end

endmodule

// File: rtl/machine_trap_csr.sv
// Machine-mode trap CSR bank: holds mstatus/mie/mip/mtvec/mepc/mcause/mscratch,
// responds to trap commands from the control path and serves Zicsr accesses.
module machine_trap_csr
  import machine_trap_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] CSR_ADDR,
  input  logic [1:0]  CSR_OP,
  input  logic        CSR_WR_EN,
  input  logic [31:0] CSR_WDATA,
  output logic [31:0] CSR_RDATA,
  input  logic [31:0] PC,
  input  logic        E_IRQ,
  input  logic        T_IRQ,
  input  logic        I_OR_E,
  input  logic        SET_EPC,
  input  logic        SET_CAUSE,
  input  logic        MIE_CLEAR,
  input  logic        MIE_SET,
  input  logic [3:0]  CAUSE,
  output logic        MIE,
  output logic        MEIE,
  output logic        MTIE,
  output logic        MSIE,
  output logic        MEIP,
  output logic        MTIP,
  output logic        MSIP,
  output logic [31:0] TRAP_ADDRESS,
  output logic [31:0] EPC_OUT
);

  logic        status_mie, status_mpie;
  logic        en_meie, en_mtie, en_msie;
  logic        pend_meip, pend_mtip, pend_msip;
  logic [29:0] tvec_base;
  logic [1:0]  tvec_mode;
  logic [31:0] epc_reg;
  logic        cause_int;
  logic [3:0]  cause_code;
  logic [31:0] scratch_reg;

  logic [31:0] old_value;
  logic [31:0] new_value;
  logic        csr_we;
  logic [31:0] base_addr;
  logic [31:0] vec_offset;

  assign csr_we = CSR_WR_EN && (CSR_OP != OP_NONE);

  // Old value at the accessed address; doubles as the read data (no bypass).
  always_comb begin
    old_value = 32'h0;
    case (CSR_ADDR)
      ADDR_MSTATUS: begin
        old_value[12:11] = 2'b11;
        old_value[7]     = status_mpie;
        old_value[3]     = status_mie;
      end
      ADDR_MIE: begin
        old_value[11] = en_meie;
        old_value[7]  = en_mtie;
        old_value[3]  = en_msie;
      end
      ADDR_MTVEC:    old_value = {tvec_base, tvec_mode};
      ADDR_MSCRATCH: old_value = scratch_reg;
      ADDR_MEPC:     old_value = epc_reg;
      ADDR_MCAUSE:   old_value = {cause_int, 27'b0, cause_code};
      ADDR_MIP: begin
        old_value[11] = pend_meip;
        old_value[7]  = pend_mtip;
        old_value[3]  = pend_msip;
      end
      default:       old_value = 32'h0;
    endcase
  end

  csr_rmw_unit u_rmw (
    .old_value (old_value),
    .op        (CSR_OP),
    .wdata     (CSR_WDATA),
    .new_value (new_value)
  );

  // mstatus: trap entry/return commands take precedence over software writes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
    end else if (MIE_CLEAR) begin
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
    end else if (MIE_SET) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (csr_we && (CSR_ADDR == ADDR_MSTATUS)) begin
      status_mie  <= new_value[3];
      status_mpie <= new_value[7];
    end
  end

  // mie enables are software-owned.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_meie <= 1'b0;
      en_mtie <= 1'b0;
      en_msie <= 1'b0;
    end else if (csr_we && (CSR_ADDR == ADDR_MIE)) begin
      en_meie <= new_value[11];
      en_mtie <= new_value[7];
      en_msie <= new_value[3];
    end
  end

  // mip: external/timer pending track the request lines; only MSIP is writable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pend_meip <= 1'b0;
      pend_mtip <= 1'b0;
      pend_msip <= 1'b0;
    end else begin
      pend_meip <= E_IRQ;
      pend_mtip <= T_IRQ;
      if (csr_we && (CSR_ADDR == ADDR_MIP)) begin
        pend_msip <= new_value[3];
      end
    end
  end

  // mtvec: illegal or disabled modes are stored as direct.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tvec_base <= MTVEC_RESET[31:2];
      tvec_mode <= legal_mode(MTVEC_RESET[1:0], VECTORED_EN);
    end else if (csr_we && (CSR_ADDR == ADDR_MTVEC)) begin
      tvec_base <= new_value[31:2];
      tvec_mode <= legal_mode(new_value[1:0], VECTORED_EN);
    end
  end

  // mepc: trap entry captures the word-aligned PC ahead of any software write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      epc_reg <= 32'h0;
    end else if (SET_EPC) begin
      epc_reg <= PC & 32'hFFFF_FFFC;
    end else if (csr_we && (CSR_ADDR == ADDR_MEPC)) begin
      epc_reg <= new_value & 32'hFFFF_FFFC;
    end
  end

  // mcause: trap entry beats software for both the interrupt flag and code.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cause_int  <= 1'b0;
      cause_code <= 4'h0;
    end else if (SET_CAUSE) begin
      cause_int  <= I_OR_E;
      cause_code <= CAUSE;
    end else if (csr_we && (CSR_ADDR == ADDR_MCAUSE)) begin
      cause_int  <= new_value[31];
      cause_code <= new_value[3:0];
    end
  end

  // mscratch is a plain software scratch register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scratch_reg <= 32'h0;
    end else if (csr_we && (CSR_ADDR == ADDR_MSCRATCH)) begin
      scratch_reg <= new_value;
    end
  end

  // Trap target comes from the live CAUSE/I_OR_E inputs so the PC mux can use
  // it in the very cycle the trap is taken; the add wraps at 32 bits.
  assign base_addr    = {tvec_base, 2'b00};
  assign vec_offset   = {26'b0, CAUSE, 2'b00};
  assign TRAP_ADDRESS = ((tvec_mode == MODE_VECTORED) && I_OR_E) ? (base_addr + vec_offset)
                                                                 : base_addr;

  assign CSR_RDATA = old_value;
  assign EPC_OUT   = epc_reg;
  assign MIE       = status_mie;
  assign MEIE      = en_meie;
  assign MTIE      = en_mtie;
  assign MSIE      = en_msie;
  assign MEIP      = pend_meip;
  assign MTIP      = pend_mtip;
  assign MSIP      = pend_msip;

  // Entering and leaving a trap in the same cycle is never legal.
  no_clear_and_set: assert property (@(posedge CLK) disable iff (!RESET) !(MIE_CLEAR && MIE_SET));

endmodule

// File: tb/tb_machine_trap_csr.sv
// Directed self-checking bench for machine_trap_csr.
module tb_machine_trap_csr;

  logic        CLK;
  logic        RESET;
  logic [11:0] CSR_ADDR;
  logic [1:0]  CSR_OP;
  logic        CSR_WR_EN;
  logic [31:0] CSR_WDATA;
  logic [31:0] CSR_RDATA;
  logic [31:0] PC;
  logic        E_IRQ, T_IRQ, I_OR_E, SET_EPC, SET_CAUSE, MIE_CLEAR, MIE_SET;
  logic [3:0]  CAUSE;
  logic        MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP;
  logic [31:0] TRAP_ADDRESS;
  logic [31:0] EPC_OUT;

  int check_count = 0;
  int error_count = 0;

  machine_trap_csr #(
    .MTVEC_RESET (32'h0000_1000),
    .VECTORED_EN (1'b1)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CSR_ADDR     (CSR_ADDR),
    .CSR_OP       (CSR_OP),
    .CSR_WR_EN    (CSR_WR_EN),
    .CSR_WDATA    (CSR_WDATA),
    .CSR_RDATA    (CSR_RDATA),
    .PC           (PC),
    .E_IRQ        (E_IRQ),
    .T_IRQ        (T_IRQ),
    .I_OR_E       (I_OR_E),
    .SET_EPC      (SET_EPC),
    .SET_CAUSE    (SET_CAUSE),
    .MIE_CLEAR    (MIE_CLEAR),
    .MIE_SET      (MIE_SET),
    .CAUSE        (CAUSE),
    .MIE          (MIE),
    .MEIE         (MEIE),
    .MTIE         (MTIE),
    .MSIE         (MSIE),
    .MEIP         (MEIP),
    .MTIP         (MTIP),
    .MSIP         (MSIP),
    .TRAP_ADDRESS (TRAP_ADDRESS),
    .EPC_OUT      (EPC_OUT)
  );

  // Free-running 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op,
                               input logic [31:0] wdata, input logic we);
    CSR_ADDR  = addr;
    CSR_OP    = op;
    CSR_WDATA = wdata;
    CSR_WR_EN = we;
  endtask

  task automatic stepClock();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clearTrap();
    SET_EPC   = 1'b0;
    SET_CAUSE = 1'b0;
    MIE_CLEAR = 1'b0;
    MIE_SET   = 1'b0;
    I_OR_E    = 1'b0;
    CAUSE     = 4'h0;
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata);
    applyStimulus(addr, op, wdata, 1'b1);
    stepClock();
    applyStimulus(12'h000, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] expected);
    applyStimulus(addr, 2'b00, 32'h0, 1'b0);
    #1;
    checkOutput(tag, CSR_RDATA, expected);
  endtask

  initial begin
    RESET = 1'b0;
    PC    = 32'h0;
    E_IRQ = 1'b0;
    T_IRQ = 1'b0;
    clearTrap();
    applyStimulus(12'h000, 2'b00, 32'h0, 1'b0);

    // Reset state
    #12;
    checkOutput("rst_trap_addr", TRAP_ADDRESS, 32'h0000_1000);
    checkOutput("rst_epc_out", EPC_OUT, 32'h0);
    checkOutput("rst_bits", {25'b0, MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    stepClock();
    readCheck("rd_mstatus", 12'h300, 32'h0000_1800);
    readCheck("rd_mie", 12'h304, 32'h0);
    readCheck("rd_mtvec", 12'h305, 32'h0000_1000);
    readCheck("rd_mscratch", 12'h340, 32'h0);
    readCheck("rd_mepc", 12'h341, 32'h0);
    readCheck("rd_mcause", 12'h342, 32'h0);
    readCheck("rd_mip", 12'h344, 32'h0);
    readCheck("rd_unmapped", 12'h123, 32'h0);
    @(negedge CLK);

    // Vectored trap address
    csrWrite(12'h305, 2'b01, 32'h0000_2001);
    readCheck("mtvec_vec", 12'h305, 32'h0000_2001);
    SET_CAUSE = 1'b1;
    I_OR_E    = 1'b1;
    CAUSE     = 4'b0111;
    #1;
    checkOutput("trap_vec_irq", TRAP_ADDRESS, 32'h0000_201C);
    I_OR_E = 1'b0;
    #1;
    checkOutput("trap_vec_exc", TRAP_ADDRESS, 32'h0000_2000);
    I_OR_E = 1'b1;
    stepClock();
    clearTrap();
    readCheck("mcause_set", 12'h342, 32'h8000_0007);
    @(negedge CLK);
    csrWrite(12'h305, 2'b01, 32'h0000_2003);
    readCheck("mtvec_bad_mode", 12'h305, 32'h0000_2000);
    @(negedge CLK);
    csrWrite(12'h305, 2'b01, 32'hFFFF_FFFD);
    I_OR_E = 1'b1;
    CAUSE  = 4'b0111;
    #1;
    checkOutput("trap_wrap", TRAP_ADDRESS, 32'h0000_0018);
    clearTrap();
    @(negedge CLK);

    // Trap entry and return
    csrWrite(12'h300, 2'b10, 32'h0000_0008);
    checkOutput("mie_set_by_rs", {31'b0, MIE}, 32'h1);
    readCheck("mstatus_mie", 12'h300, 32'h0000_1808);
    @(negedge CLK);
    PC        = 32'h0000_0446;
    SET_EPC   = 1'b1;
    SET_CAUSE = 1'b1;
    MIE_CLEAR = 1'b1;
    CAUSE     = 4'h3;
    stepClock();
    clearTrap();
    checkOutput("epc_out", EPC_OUT, 32'h0000_0444);
    readCheck("rd_mepc_trap", 12'h341, 32'h0000_0444);
    readCheck("rd_mcause_trap", 12'h342, 32'h0000_0003);
    readCheck("mstatus_entry", 12'h300, 32'h0000_1880);
    @(negedge CLK);
    MIE_SET = 1'b1;
    stepClock();
    clearTrap();
    readCheck("mstatus_return", 12'h300, 32'h0000_1888);
    @(negedge CLK);

    // Hardware wins over a same-cycle CSR write
    csrWrite(12'h300, 2'b11, 32'h0000_0088);
    readCheck("mstatus_cleared", 12'h300, 32'h0000_1800);
    @(negedge CLK);
    applyStimulus(12'h300, 2'b10, 32'h0000_0008, 1'b1);
    MIE_CLEAR = 1'b1;
    stepClock();
    clearTrap();
    applyStimulus(12'h000, 2'b00, 32'h0, 1'b0);
    checkOutput("hw_beats_rs", {31'b0, MIE}, 32'h0);
    applyStimulus(12'h341, 2'b01, 32'h0000_1237, 1'b1);
    SET_EPC = 1'b1;
    PC      = 32'h0000_5557;
    stepClock();
    clearTrap();
    applyStimulus(12'h000, 2'b00, 32'h0, 1'b0);
    checkOutput("epc_beats_rw", EPC_OUT, 32'h0000_5554);
    csrWrite(12'h341, 2'b01, 32'h0000_1237);
    checkOutput("mepc_align", EPC_OUT, 32'h0000_1234);

    // Enables and pending bits
    csrWrite(12'h304, 2'b01, 32'hFFFF_FFFF);
    checkOutput("mie_bits", {29'b0, MEIE, MTIE, MSIE}, 32'h7);
    readCheck("rd_mie_all", 12'h304, 32'h0000_0888);
    @(negedge CLK);
    csrWrite(12'h304, 2'b11, 32'h0000_0080);
    readCheck("rd_mie_rc", 12'h304, 32'h0000_0808);
    @(negedge CLK);
    E_IRQ = 1'b1;
    #1;
    checkOutput("meip_latency", {31'b0, MEIP}, 32'h0);
    @(negedge CLK);
    checkOutput("meip_set", {31'b0, MEIP}, 32'h1);
    csrWrite(12'h344, 2'b11, 32'h0000_0800);
    checkOutput("meip_not_writable", {31'b0, MEIP}, 32'h1);
    csrWrite(12'h344, 2'b10, 32'h0000_0008);
    checkOutput("msip_set", {31'b0, MSIP}, 32'h1);
    readCheck("rd_mip", 12'h344, 32'h0000_0808);
    @(negedge CLK);
    T_IRQ = 1'b1;
    stepClock();
    readCheck("rd_mip_timer", 12'h344, 32'h0000_0888);
    @(negedge CLK);
    csrWrite(12'h344, 2'b01, 32'h0000_0000);
    readCheck("rd_mip_rw0", 12'h344, 32'h0000_0880);
    @(negedge CLK);

    // Asynchronous reset mid-sequence
    csrWrite(12'h340, 2'b01, 32'hDEAD_BEEF);
    readCheck("mscratch_wr", 12'h340, 32'hDEAD_BEEF);
    #1;
    RESET = 1'b0;
    #1;
    checkOutput("async_mscratch", CSR_RDATA, 32'h0);
    checkOutput("async_trap_addr", TRAP_ADDRESS, 32'h0000_1000);
    checkOutput("async_bits", {25'b0, MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP}, 32'h0);
    checkOutput("async_epc", EPC_OUT, 32'h0);
    @(negedge CLK);
    E_IRQ = 1'b0;
    T_IRQ = 1'b0;
    RESET = 1'b1;
    stepClock();
    readCheck("post_rst_mstatus", 12'h300, 32'h0000_1800);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/machine_trap_csr.md
Name: machine_trap_csr

Overview:
M-mode trap CSR bank for Steel Core; it is the responder side of the machine_control trap interface.
- Consumes trap commands (SET_EPC, SET_CAUSE, CAUSE, I_OR_E, MIE_CLEAR, MIE_SET).
- Holds mstatus/mie/mip/mtvec/mepc/mcause/mscratch.
- Returns the enable and pending bits plus the trap target and return addresses to the control path and PC mux.
- Serves Zicsr read/modify/write accesses from pipeline stage 3.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE and MODE).
- VECTORED_EN, 1, 1 allows mtvec.MODE=01 (vectored); 0 forces MODE reads and writes to 00.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CSR_ADDR  in  12  CSR address.
- CSR_OP  in  2  01 RW, 10 RS, 11 RC, 00 none.
- CSR_WR_EN  in  1  commit the CSR access this cycle.
- CSR_WDATA  in  32  rs1 value or zero-extended uimm.
- CSR_RDATA  out  32  combinational old value at CSR_ADDR.
- PC  in  32  PC of the trapping or interrupted instruction.
- E_IRQ, T_IRQ  in  1 each  external and timer interrupt request levels.
- I_OR_E, SET_EPC, SET_CAUSE, MIE_CLEAR, MIE_SET  in  1 each  trap commands.
- CAUSE  in  4  trap cause code.
- MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP  out  1 each  status, enable and pending bits.
- TRAP_ADDRESS  out  32  trap target for the PC mux.
- EPC_OUT  out  32  mepc, for mret.

Behaviour:
- Reset (RESET=0, asynchronous):
  - mstatus.MIE=0, MPIE=0; mie=0; MSIP=0; MEIP=MTIP=0.
  - mtvec=MTVEC_RESET; mepc=0; mcause=0 (I_OR_E=0, CAUSE=0); mscratch=0.
  - All outputs follow these registers immediately.
- Address map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits12:11 read 11, all other bits 0.
  - mie 0x304: bits 11/7/3 = MEIE/MTIE/MSIE.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits1:0 always 0.
  - mcause 0x342: reads {I_OR_E, 27'b0, CAUSE}.
  - mip 0x344: bits 11/7/3 = MEIP/MTIP/MSIP; only MSIP is writable.
  - Any other address: reads 0, writes ignored.
- CSR write, only when CSR_WR_EN=1 and CSR_OP!=00; new value is:
  - RW: WDATA.
  - RS: old | WDATA.
  - RC: old & ~WDATA.
  - Commits at the next edge. Read-only and hardwired bits are masked. An mtvec MODE value other than 00/01 is written as 00.
- Pending bits: MEIP<=E_IRQ and MTIP<=T_IRQ every cycle (one-cycle latency); CSR writes to these bits are ignored.
- Trap entry, same edge:
  - SET_EPC: mepc<={PC[31:2],2'b00}.
  - SET_CAUSE: mcause<={I_OR_E,CAUSE}.
  - MIE_CLEAR: MPIE<=MIE, MIE<=0.
- Trap return, MIE_SET: MIE<=MPIE, MPIE<=1.
- MIE_CLEAR and MIE_SET both high: MIE_CLEAR wins (not legal; flag in an assertion).
- Priority: a hardware trap update beats a CSR write to the same field in the same cycle. The CSR write to non-conflicting fields still commits.
- TRAP_ADDRESS is combinational from the CAUSE/I_OR_E inputs, not from the mcause register, because the PC mux consumes it in the same cycle SET_CAUSE is high:
  - MODE=01 and I_OR_E=1: {BASE,2'b00} + (CAUSE<<2).
  - Otherwise: {BASE,2'b00}.
  - The add wraps modulo 2^32.
- EPC_OUT = mepc register.
- CSR_RDATA = current register value, pre-update; no bypass.

Decomposition:
- globals.vh gets:
  - CSR address constants (MSTATUS, MIE, MTVEC, MSCRATCH, MEPC, MCAUSE, MIP).
  - CSR_OP encodings.
  - mtvec MODE encodings.
- Sub-module csr_rmw_unit: combinational old/op/wdata -> new value. It is instantiated once and shared by all registers.

Test Plan:
1. Reset release, then read 0x305 with MTVEC_RESET=32'h0000_1000 -> CSR_RDATA=32'h0000_1000. Every other CSR reads 0 except mstatus=32'h0000_1800.
2. RW mtvec=32'h0000_2001, then one cycle with I_OR_E=1, CAUSE=4'b0111, SET_CAUSE=1 -> TRAP_ADDRESS=32'h0000_201C. The same cycle with I_OR_E=0 -> 32'h0000_2000.
3. MIE=1 via RS 0x300 with 32'h8. Pulse SET_EPC/SET_CAUSE/MIE_CLEAR with PC=32'h0000_0446 -> mepc=32'h0000_0444, MIE=0, MPIE=1. Then pulse MIE_SET -> MIE=1, MPIE=1.
4. RS mstatus with 32'h8 in the same cycle as MIE_CLEAR -> MIE=0 after the edge (hardware wins).
5. E_IRQ=1 -> MEIP=1 one cycle later. A CSR RC to mip with 32'h800 leaves MEIP=1; RS with 32'h8 sets MSIP=1.
6. RESET low mid-sequence with mscratch=32'hDEADBEEF -> mscratch reads 0 without waiting for a clock edge.
